// File: rtl/lif_neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_pkg
// Purpose  : Shared widths and fixed-point constants for the LIF neuron.
// Revision : 1.0 - initial release
// ============================================================================
package lif_neuron_pkg;

  // Batch-norm factor carries one fractional bit (2 means x1.0).
  localparam int BN_FRAC_BITS = 1;

  // Membrane width: large enough for a full-scale scaled synaptic sum.
  function automatic int mem_bits(input int synapses);
    return $clog2(synapses) + 5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_sign_extend.sv
`default_nettype none
// ============================================================================
// Module   : sign_extend
// Purpose  : Widen a two's-complement value by replicating its MSB.
// Revision : 1.0 - initial release
// ============================================================================
module sign_extend #(
  parameter int IN_BITS  = 5,
  parameter int OUT_BITS = 10
) (
  input  logic [IN_BITS-1:0]  value_i,
  output logic [OUT_BITS-1:0] value_o
);

  generate
    if (OUT_BITS > IN_BITS) begin : g_widen
      assign value_o = {{(OUT_BITS-IN_BITS){value_i[IN_BITS-1]}}, value_i};
    end else begin : g_pass
      // Equal widths: nothing to replicate.
      assign value_o = value_i[OUT_BITS-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron
// Purpose  : Leaky integrate-and-fire neuron with binary weights, batch-norm
//            scale/offset, shift leak and reset-by-subtraction spiking.
// Options  : LIF_SATURATE_EN - clamp membrane to MEM_BITS range instead of
//            two's-complement wrap.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron
  import lif_neuron_pkg::*;
#(
  parameter int SYNAPSES              = 32,
  parameter int THRESHOLD_BITS        = 6,
  parameter int BATCHNORM_ADDEND_BITS = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [SYNAPSES-1:0]              inputs,
  input  logic [SYNAPSES-1:0]              weights,
  input  logic [3:0]                       batchnorm_factor,
  input  logic [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
  input  logic [2:0]                       shift,
  input  logic [THRESHOLD_BITS-1:0]        threshold,
  output logic                             is_spike
);

  localparam int MEM_BITS  = mem_bits(SYNAPSES);
  localparam int SUM_BITS  = $clog2(SYNAPSES) + 2;
  // Headroom so that leak, scale and offset never overflow before reduction.
  localparam int WIDE_BITS = MEM_BITS + 4;

  localparam logic signed [WIDE_BITS-1:0] c_mem_max = WIDE_BITS'((1 << (MEM_BITS-1)) - 1);
  localparam logic signed [WIDE_BITS-1:0] c_mem_min = -c_mem_max - WIDE_BITS'(1);

  logic signed [MEM_BITS-1:0]  u_q, u_d;
  logic                        spike_q, spike_d;

  logic signed [SUM_BITS-1:0]  w_sum;
  logic signed [WIDE_BITS-1:0] w_sum_wide, w_factor_wide, w_scaled;
  logic        [MEM_BITS-1:0]  w_addend_mem;
  logic signed [WIDE_BITS-1:0] w_addend_wide, w_y;
  logic signed [WIDE_BITS-1:0] w_u_wide, w_u_next, w_u_next_fit;
  logic signed [WIDE_BITS-1:0] w_thr_wide, w_post_fit;

  // Reduce a wide intermediate back to the membrane range.
  function automatic logic signed [WIDE_BITS-1:0] fit_mem(input logic signed [WIDE_BITS-1:0] v);
`ifdef LIF_SATURATE_EN
    if (v > c_mem_max)      fit_mem = c_mem_max;
    else if (v < c_mem_min) fit_mem = c_mem_min;
    else                    fit_mem = v;
`else
    fit_mem = WIDE_BITS'(signed'(v[MEM_BITS-1:0]));
`endif
  endfunction

  // Signed synaptic sum: +1 for active excitatory, -1 for active inhibitory.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (inputs[i]) begin
        if (weights[i]) w_sum = w_sum + SUM_BITS'(1);
        else            w_sum = w_sum - SUM_BITS'(1);
      end
    end
  end

  sign_extend #(
    .IN_BITS  (BATCHNORM_ADDEND_BITS),
    .OUT_BITS (MEM_BITS)
  ) u_addend_ext (
    .value_i (batchnorm_addend),
    .value_o (w_addend_mem)
  );

  // Batch-norm scale (arithmetic shift floors toward -inf), then offset.
  assign w_sum_wide    = WIDE_BITS'(w_sum);
  assign w_factor_wide = signed'(WIDE_BITS'(batchnorm_factor));
  assign w_scaled      = (w_sum_wide * w_factor_wide) >>> BN_FRAC_BITS;
  assign w_addend_wide = WIDE_BITS'(signed'(w_addend_mem));
  assign w_y           = w_scaled + w_addend_wide;

  // Leak: shift of 0 cancels u entirely, leaving u_next = y.
  assign w_u_wide     = WIDE_BITS'(u_q);
  assign w_u_next     = w_u_wide - (w_u_wide >>> shift) + w_y;
  assign w_u_next_fit = fit_mem(w_u_next);

  // Unsigned threshold compared against the signed membrane.
  assign w_thr_wide = signed'(WIDE_BITS'(threshold));
  assign w_post_fit = fit_mem(w_u_next_fit - w_thr_wide);

  // Spike decision and reset-by-subtraction.
  always_comb begin
    spike_d = (w_u_next_fit >= w_thr_wide);
    u_d     = spike_d ? MEM_BITS'(w_post_fit) : MEM_BITS'(w_u_next_fit);
  end

  // Membrane and spike registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_q     <= '0;
      spike_q <= 1'b0;
    end else if (enable) begin
      u_q     <= u_d;
      spike_q <= spike_d;
    end
  end

  assign is_spike = spike_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron
// Purpose  : Scoreboard bench for lif_neuron (16 synapses, 9-bit membrane).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

  localparam int SYN = 16;
  localparam int TB  = 5;
  localparam int AB  = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [SYN-1:0] inputs = '0;
  logic [SYN-1:0] weights = 16'hFFFF;
  logic [3:0]     factor = 4'd2;
  logic [AB-1:0]  addend = '0;
  logic [2:0]     shift = 3'd4;
  logic [TB-1:0]  threshold = 5'd9;
  logic           is_spike;

  typedef struct { int u; int spk; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int m_u   = 0;
  int m_spk = 0;

  lif_neuron #(
    .SYNAPSES              (SYN),
    .THRESHOLD_BITS        (TB),
    .BATCHNORM_ADDEND_BITS (AB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .inputs           (inputs),
    .weights          (weights),
    .batchnorm_factor (factor),
    .batchnorm_addend (addend),
    .shift            (shift),
    .threshold        (threshold),
    .is_spike         (is_spike)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // 9-bit membrane reduction.
  function automatic int fit(input int v);
    int r;
`ifdef LIF_SATURATE_EN
    r = (v > 255) ? 255 : ((v < -256) ? -256 : v);
`else
    r = v & 511;
    if (r >= 256) r = r - 512;
`endif
    return r;
  endfunction

  // Reference neuron step using the current drive values.
  task automatic model_step();
    int sum, y, un, thr, a;
    sum = 0;
    for (int i = 0; i < SYN; i++)
      if (inputs[i]) sum = sum + (weights[i] ? 1 : -1);
    a   = $signed(addend);
    y   = ((sum * int'(factor)) >>> 1) + a;
    un  = fit(m_u - (m_u >>> shift) + y);
    thr = int'(threshold);
    if (un >= thr) begin
      m_spk = 1;
      m_u   = fit(un - thr);
    end else begin
      m_spk = 0;
      m_u   = un;
    end
  endtask

  // Drive one cycle, push the expectation, compare after the edge.
  task automatic step(input string tag, input bit rst, input bit en);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    enable = en;
    if (rst) begin
      m_u = 0; m_spk = 0;
    end else if (en) begin
      model_step();
    end
    exp_q.push_back('{u: m_u, spk: m_spk});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_u"}, int'(dut.u_q), e.u);
      check({tag, "_spk"}, int'(is_spike), e.spk);
    end
  endtask

  task automatic defaults();
    weights = 16'hFFFF; factor = 4'd2; addend = '0;
    shift = 3'd4; threshold = 5'd9; inputs = '0;
  endtask

  initial begin
    defaults();
    step("reset0", 1'b1, 1'b0);
    step("reset1", 1'b1, 1'b1);

    // Integration to spike: 4, 8, 12->3 spike, 7.
    inputs = 16'h000F;
    for (int i = 0; i < 4; i++) step("integ", 1'b0, 1'b1);

    // Enable hold from u = 8.
    step("rst_a", 1'b1, 1'b1);
    step("integ8", 1'b0, 1'b1);
    step("integ8", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      inputs = 16'($urandom);
      step("hold", 1'b0, 1'b0);
    end
    inputs = 16'h000F;
    step("resume", 1'b0, 1'b1);

    // Reset right after a spike, then first enabled cycle gives u = y.
    step("rst_mid", 1'b1, 1'b1);
    step("after_rst", 1'b0, 1'b1);

    // Negative weights and leak: -4, -7.
    weights = 16'h0000;
    step("rst_b", 1'b1, 1'b1);
    step("neg", 1'b0, 1'b1);
    step("neg", 1'b0, 1'b1);

    // Batch-norm scale and negative offset.
    defaults();
    factor = 4'd3; addend = 4'b1110; inputs = 16'h0003; threshold = 5'd31;
    step("rst_c", 1'b1, 1'b1);
    step("bn", 1'b0, 1'b1);
    step("bn", 1'b0, 1'b1);

    // Large drive: saturation or wrap depending on build.
    factor = 4'd15; addend = 4'd7; inputs = 16'hFFFF; threshold = 5'd31;
    step("rst_d", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("sat", 1'b0, 1'b1);

    // Threshold zero and shift zero corners.
    defaults();
    threshold = '0; shift = 3'd0; inputs = 16'h0001;
    step("thr0", 1'b0, 1'b1);

    // Randomised operation.
    for (int i = 0; i < 40; i++) begin
      inputs    = 16'($urandom);
      weights   = 16'($urandom);
      factor    = 4'($urandom);
      addend    = 4'($urandom);
      shift     = 3'($urandom);
      threshold = 5'($urandom);
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
